wb_stage_pipe: RTL and testbench

Registered, parametrised writeback stage for the 5-stage MIPS pipeline. It takes the MEM/WB bundle through a valid/ready handshake and selects PC+4, load data, ALU result or upper-immediate data. Load data may arrive later, through a memory response handshake with a timeout. It drives the register-file write port one cycle after data is available, and reports a pending destination to the hazard unit while a load is outstanding.

---
 rtl/wb_stage_pipe.sv | 153 +++++++++++++++
 tb/tb_wb_stage_pipe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_pipe.sv
// MIPS writeback stage: accepts the MEM/WB bundle and selects the write data.
// Tracks one outstanding load with a timeout. Optional counters: `define WB_STATS_EN.
module wb_stage_pipe #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        control_in,
  input  logic [DATA_W-1:0] pc_4,
  input  logic [DATA_W-1:0] data_alu,
  input  logic [DATA_W-1:0] data_imm,
  input  logic [REG_AW-1:0] regdst_in,
  input  logic              flush,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              reg_write,
  output logic [REG_AW-1:0] regdst_out,
  output logic [DATA_W-1:0] data_to_reg,
  output logic              pend_valid,
  output logic [REG_AW-1:0] pend_addr,
  output logic              mem_err
`ifdef WB_STATS_EN
  ,
  output logic [31:0]       wb_count,
  output logic [31:0]       stall_count
`endif
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(MEM_TIMEOUT);

  localparam logic [1:0] SEL_PC4  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_ALU  = 2'b10;

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_we;
  logic              accept;
  logic [1:0]        sel;
  logic [DATA_W-1:0] sel_data;
  logic              wr_d;
  logic [REG_AW-1:0] waddr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              err_d;
  logic              latch_d;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready && !flush;
  assign sel      = control_in[2:1];

  always_comb begin
    case (sel)
      SEL_PC4:  sel_data = pc_4;
      SEL_LOAD: sel_data = mem_rdata;
      SEL_ALU:  sel_data = data_alu;
      default:  sel_data = data_imm;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = 1'b0;
    waddr_d = regdst_in;
    wdata_d = sel_data;
    err_d   = 1'b0;
    latch_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (sel == SEL_LOAD && !mem_rvalid) begin
            state_d = WAIT_MEM;
            cnt_d   = '0;
            latch_d = 1'b1;
          end else begin
            wr_d = control_in[0] && (regdst_in != '0);
          end
        end
      end
      WAIT_MEM: begin
        waddr_d = pend_addr;
        wdata_d = mem_rdata;
        if (flush) begin
          state_d = IDLE;
        end else if (mem_rvalid) begin
          state_d = IDLE;
          wr_d    = pend_we && (pend_addr != '0);
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (MEM_TIMEOUT > 0 && cnt_d == TIMEOUT_V) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: async reset lands the FSM and every output register at a known value at once.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      reg_write   <= 1'b0;
      regdst_out  <= '0;
      data_to_reg <= '0;
      pend_valid  <= 1'b0;
      pend_addr   <= '0;
      pend_we     <= 1'b0;
      mem_err     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      reg_write  <= wr_d;
      mem_err    <= err_d;
      pend_valid <= (state_d == WAIT_MEM);
      // Write address/data only move on a real write so they hold between pulses.
      if (wr_d) begin
        regdst_out  <= waddr_d;
        data_to_reg <= wdata_d;
      end
      if (latch_d) begin
        pend_addr <= regdst_in;
        pend_we   <= control_in[0];
      end
    end
  end

`ifdef WB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_count    <= '0;
      stall_count <= '0;
    end else begin
      if (reg_write && wb_count != '1)
        wb_count <= wb_count + 32'd1;
      if (state_q == WAIT_MEM && stall_count != '1)
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Self-checking bench for wb_stage_pipe: directed plan steps plus randomized
// transactions checked against a transaction-level model of the writeback rules.
module tb_wb_stage_pipe;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int TO     = 15;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        control_in = '0;
  logic [DATA_W-1:0] pc_4 = '0;
  logic [DATA_W-1:0] data_alu = '0;
  logic [DATA_W-1:0] data_imm = '0;
  logic [REG_AW-1:0] regdst_in = '0;
  logic              flush = 1'b0;
  logic              mem_rvalid = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              reg_write;
  logic [REG_AW-1:0] regdst_out;
  logic [DATA_W-1:0] data_to_reg;
  logic              pend_valid;
  logic [REG_AW-1:0] pend_addr;
  logic              mem_err;

  always #5 clk = ~clk;

  wb_stage_pipe #(.DATA_W(DATA_W), .REG_AW(REG_AW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .control_in(control_in), .pc_4(pc_4), .data_alu(data_alu), .data_imm(data_imm),
    .regdst_in(regdst_in), .flush(flush), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .reg_write(reg_write), .regdst_out(regdst_out), .data_to_reg(data_to_reg),
    .pend_valid(pend_valid), .pend_addr(pend_addr), .mem_err(mem_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: last committed write address/data (held between pulses).
  logic [REG_AW-1:0] exp_addr = '0;
  logic [DATA_W-1:0] exp_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] sel_val(input logic [1:0] s, input logic [DATA_W-1:0] pc,
      input logic [DATA_W-1:0] ld, input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] imm);
    if (s == 2'd0) return pc;
    if (s == 2'd1) return ld;
    if (s == 2'd2) return alu;
    return imm;
  endfunction

  task automatic expect_wr(input string tag, input bit we, input logic [REG_AW-1:0] a,
      input logic [DATA_W-1:0] d);
    if (we) begin
      exp_addr = a;
      exp_data = d;
    end
    check({tag, "_we"},   32'(reg_write), 32'(we));
    check({tag, "_addr"}, 32'(regdst_out), 32'(exp_addr));
    check({tag, "_data"}, data_to_reg, exp_data);
  endtask

  // One bundle: d = cycles from accept to mem_rvalid (0 = same cycle); d > TO never answers.
  task automatic txn(input string tag, input logic [2:0] ctrl, input logic [REG_AW-1:0] rd,
      input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] rdata, input int d,
      input bit fl_acc, input bit fl_wait);
    bit is_load;
    bit we;
    int n_wait;
    logic [DATA_W-1:0] val;
    is_load    = (ctrl[2:1] == 2'b01);
    we         = ctrl[0] && (rd != '0);
    pc_4       = $urandom;
    data_imm   = $urandom;
    data_alu   = alu;
    in_valid   = 1'b1;
    control_in = ctrl;
    regdst_in  = rd;
    mem_rdata  = rdata;
    mem_rvalid = is_load && (d == 0);
    flush      = fl_acc;
    val        = sel_val(ctrl[2:1], pc_4, rdata, alu, data_imm);
    check({tag, "_rdy_acc"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; flush = 1'b0; mem_rvalid = 1'b0;
    pc_4 = $urandom; data_alu = $urandom; data_imm = $urandom; mem_rdata = $urandom;
    regdst_in = 5'($urandom);
    if (fl_acc) begin
      expect_wr({tag, "_fla"}, 1'b0, rd, val);
    end else if (!is_load || d == 0) begin
      expect_wr(tag, we, rd, val);
    end else begin
      n_wait = (d > TO) ? TO : d;
      for (int c = 1; c <= n_wait; c++) begin
        check({tag, "_pv"},  32'(pend_valid), 32'd1);
        check({tag, "_pa"},  32'(pend_addr), 32'(rd));
        check({tag, "_rdy"}, 32'(in_ready), 32'd0);
        check({tag, "_nwr"}, 32'(reg_write), 32'd0);
        if (c == d) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rdata;
          flush      = fl_wait;
        end
        tick();
        mem_rvalid = 1'b0; flush = 1'b0; mem_rdata = $urandom;
      end
      check({tag, "_err"}, 32'(mem_err), 32'(d > TO));
      expect_wr(tag, we && (d <= TO) && !fl_wait, rd, rdata);
    end
    check({tag, "_pv_end"},  32'(pend_valid), 32'd0);
    check({tag, "_rdy_end"}, 32'(in_ready), 32'd1);
    tick();
    check({tag, "_pulse"},   32'(reg_write), 32'd0);
    check({tag, "_errclr"},  32'(mem_err), 32'd0);
  endtask

  initial begin
    // Reset state, in_ready high during reset.
    #2;
    check("rst_rdy",  32'(in_ready), 32'd1);
    check("rst_we",   32'(reg_write), 32'd0);
    check("rst_addr", 32'(regdst_out), 32'd0);
    check("rst_data", data_to_reg, 32'd0);
    check("rst_pv",   32'(pend_valid), 32'd0);
    check("rst_pa",   32'(pend_addr), 32'd0);
    check("rst_err",  32'(mem_err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();

    txn("alu",   3'b101, 5'd8, 32'h1234_5678, 32'h0, 0, 1'b0, 1'b0);
    txn("zero",  3'b101, 5'd0, 32'hAAAA_0001, 32'h0, 0, 1'b0, 1'b0);
    txn("dis",   3'b100, 5'd9, 32'hAAAA_0002, 32'h0, 0, 1'b0, 1'b0);
    txn("pc4",   3'b001, 5'd31, 32'h0, 32'h0, 0, 1'b0, 1'b0);
    txn("imm",   3'b111, 5'd3, 32'h0, 32'h0, 0, 1'b0, 1'b0);
    txn("dload", 3'b011, 5'd5, 32'h0, 32'hDEAD_BEEF, 3, 1'b0, 1'b0);
    txn("sload", 3'b011, 5'd6, 32'h0, 32'hCAFE_F00D, 0, 1'b0, 1'b0);
    txn("lim15", 3'b011, 5'd7, 32'h0, 32'h0BAD_CAFE, TO, 1'b0, 1'b0);
    txn("tmo16", 3'b011, 5'd10, 32'h0, 32'h1111_2222, TO + 1, 1'b0, 1'b0);
    txn("tmo",   3'b011, 5'd11, 32'h0, 32'h3333_4444, 1000, 1'b0, 1'b0);
    txn("flw",   3'b011, 5'd12, 32'h0, 32'h5555_6666, 2, 1'b0, 1'b1);
    txn("fla",   3'b101, 5'd13, 32'h7777_8888, 32'h0, 0, 1'b1, 1'b0);
    txn("flal",  3'b011, 5'd14, 32'h0, 32'h9999_AAAA, 2, 1'b1, 1'b0);

    // mem_rvalid while idle with nothing accepted is ignored.
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_0000;
    tick();
    mem_rvalid = 1'b0;
    expect_wr("idle_rv", 1'b0, 5'd0, 32'h0);
    check("idle_rv_pv", 32'(pend_valid), 32'd0);

    // Back-to-back non-load bundles: one write per cycle.
    for (int i = 0; i < 16; i++) begin
      logic [1:0] s;
      logic [DATA_W-1:0] v;
      s = 2'($urandom_range(0, 2));
      if (s == 2'b01) s = 2'b11;
      in_valid   = 1'b1;
      control_in = {s, 1'($urandom_range(0, 3) != 0)};
      regdst_in  = 5'($urandom);
      pc_4 = $urandom; data_alu = $urandom; data_imm = $urandom; mem_rdata = $urandom;
      v = sel_val(s, pc_4, mem_rdata, data_alu, data_imm);
      check("b2b_rdy", 32'(in_ready), 32'd1);
      tick();
      expect_wr("b2b", control_in[0] && (regdst_in != '0), regdst_in, v);
    end
    in_valid = 1'b0;
    tick();
    check("b2b_pulse", 32'(reg_write), 32'd0);

    // Randomized mix of loads and non-loads with random latency and flushes.
    for (int i = 0; i < 30; i++) begin
      txn("rnd", 3'($urandom), 5'($urandom), $urandom, $urandom,
          ($urandom_range(0, 9) == 0) ? TO + 1 : int'($urandom_range(0, 6)),
          $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
    end

    // Reset mid-wait: outputs clear at once and a late mem_rvalid does nothing.
    in_valid = 1'b1; control_in = 3'b011; regdst_in = 5'd7; mem_rvalid = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    txn_reset_check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic txn_reset_check();
    check("mrst_pv_before", 32'(pend_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    exp_addr = '0;
    exp_data = '0;
    check("mrst_rdy", 32'(in_ready), 32'd1);
    check("mrst_pv",  32'(pend_valid), 32'd0);
    check("mrst_pa",  32'(pend_addr), 32'd0);
    check("mrst_err", 32'(mem_err), 32'd0);
    expect_wr("mrst", 1'b0, 5'd0, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hBEEF_BEEF;
    tick();
    mem_rvalid = 1'b0;
    expect_wr("late_rv", 1'b0, 5'd0, 32'h0);
    check("late_rv_pv", 32'(pend_valid), 32'd0);
  endtask

endmodule
